// File: rtl/data_mem_if.sv
// Load/store bus interface between the execute stage and external data memory.
// Runs the MREQ/ACKD_n handshake, formats load data and stalls the core until done.
module data_mem_if #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        core_req,
    input  logic        core_write,
    input  logic [1:0]  core_size,
    input  logic        core_uns,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic [31:0] core_rdata,
    output logic        core_stall,
    output logic        core_err,
    output logic [31:0] DAD,
    output logic        MREQ,
    output logic        WRITE,
    output logic [1:0]  SIZE,
    input  logic        ACKD_n,
    inout  wire  [31:0] DDT
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone, StErr} state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_write;
    logic        r_uns;
    logic [31:0] r_wdata;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0] r_rdata;

    logic        w_misalign;
    logic [31:0] w_wdata_rep;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_fmt;
    logic        w_drive;

    // Size 11 is handled as a word everywhere
    always_comb begin
        unique case (core_size)
            2'b01:   w_misalign = core_addr[0];
            2'b10:   w_misalign = 1'b0;
            default: w_misalign = (core_addr[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        unique case (core_size)
            2'b10:   w_wdata_rep = {4{core_wdata[7:0]}};
            2'b01:   w_wdata_rep = {2{core_wdata[15:0]}};
            default: w_wdata_rep = core_wdata;
        endcase
    end

    always_comb begin
        unique case (r_addr[1:0])
            2'b00:   w_byte = DDT[7:0];
            2'b01:   w_byte = DDT[15:8];
            2'b10:   w_byte = DDT[23:16];
            default: w_byte = DDT[31:24];
        endcase
        w_half = r_addr[1] ? DDT[31:16] : DDT[15:0];
        unique case (r_size)
            2'b10:   w_load_fmt = {{24{~r_uns & w_byte[7]}}, w_byte};
            2'b01:   w_load_fmt = {{16{~r_uns & w_half[15]}}, w_half};
            default: w_load_fmt = DDT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (core_req) begin
                    w_state_next = w_misalign ? StErr : StAccess;
                end
            end
            StAccess: begin
                // An ack on the timeout edge still completes the access
                if (!ACKD_n) begin
                    w_state_next = StDone;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_next = StErr;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_size  <= '0;
            r_write <= 1'b0;
            r_uns   <= 1'b0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == StIdle && core_req) begin
                r_addr  <= core_addr;
                r_size  <= core_size;
                r_write <= core_write;
                r_uns   <= core_uns;
                r_wdata <= w_wdata_rep;
                r_cnt   <= '0;
            end
            if (r_state == StAccess) begin
                r_cnt <= r_cnt + 1'b1;
                if (!ACKD_n && !r_write) begin
                    r_rdata <= w_load_fmt;
                end
            end
        end
    end

    always_comb begin
        MREQ       = (r_state == StAccess);
        WRITE      = (r_state == StAccess) && r_write;
        SIZE       = r_size;
        DAD        = {r_addr[31:2], 2'b00};
        core_err   = (r_state == StErr);
        core_rdata = r_rdata;
        core_stall = ((r_state == StIdle) && core_req) || (r_state == StAccess);
        w_drive    = (r_state == StAccess) && r_write;
    end

    assign DDT = w_drive ? r_wdata : 'z;

endmodule

// File: tb/tb_data_mem_if.sv
// Directed bench for data_mem_if: vector table of loads/stores plus hand-written
// timeout and mid-access reset sequences.
module tb_data_mem_if;

    localparam logic [31:0] PROBE = 32'h1234_5678;

    logic        clk;
    logic        rst;
    logic        core_req;
    logic        core_write;
    logic [1:0]  core_size;
    logic        core_uns;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        core_err;
    logic [31:0] dad;
    logic        mreq;
    logic        write_o;
    logic [1:0]  size_o;
    logic        ackd_n;
    logic        tb_en;
    logic [31:0] tb_ddt;
    wire  [31:0] ddt;

    int n_cmp;
    int n_bad;

    assign ddt = tb_en ? tb_ddt : 'z;

    data_mem_if #(
        .TIMEOUT(4),
        .CNT_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .core_req  (core_req),
        .core_write(core_write),
        .core_size (core_size),
        .core_uns  (core_uns),
        .core_addr (core_addr),
        .core_wdata(core_wdata),
        .core_rdata(core_rdata),
        .core_stall(core_stall),
        .core_err  (core_err),
        .DAD       (dad),
        .MREQ      (mreq),
        .WRITE     (write_o),
        .SIZE      (size_o),
        .ACKD_n    (ackd_n),
        .DDT       (ddt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem;
        int          waits;
        logic        err;
        logic [31:0] exp_ddt;
        logic [31:0] exp_dad;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(string name, logic wr, logic [1:0] size, logic uns,
                                logic [31:0] addr, logic [31:0] wdata, logic [31:0] mem,
                                int waits, logic err, logic [31:0] exp_ddt,
                                logic [31:0] exp_dad, logic [31:0] exp_rdata);
        vec_t v;
        v.name = name; v.wr = wr; v.size = size; v.uns = uns; v.addr = addr;
        v.wdata = wdata; v.mem = mem; v.waits = waits; v.err = err;
        v.exp_ddt = exp_ddt; v.exp_dad = exp_dad; v.exp_rdata = exp_rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left at posedge+1 with the DUT in IDLE
    task automatic run_vec(input vec_t v);
        tb_en      = 1'b0;
        core_req   = 1'b1;
        core_write = v.wr;
        core_size  = v.size;
        core_uns   = v.uns;
        core_addr  = v.addr;
        core_wdata = v.wdata;
        ackd_n     = 1'b1;
        #1;
        chk({v.name, " req stall"}, {31'd0, core_stall}, 32'd1);
        chk({v.name, " req mreq"}, {31'd0, mreq}, 32'd0);
        tick();
        if (v.err) begin
            chk({v.name, " err pulse"}, {31'd0, core_err}, 32'd1);
            chk({v.name, " err mreq"}, {31'd0, mreq}, 32'd0);
            chk({v.name, " err stall"}, {31'd0, core_stall}, 32'd0);
            core_req = 1'b0;
            tick();
            chk({v.name, " err end"}, {31'd0, core_err}, 32'd0);
            chk({v.name, " err mreq2"}, {31'd0, mreq}, 32'd0);
            chk({v.name, " rdata kept"}, core_rdata, v.exp_rdata);
        end else begin
            for (int i = 0; i <= v.waits; i++) begin
                tb_en  = ~v.wr;
                tb_ddt = v.mem;
                ackd_n = (i == v.waits) ? 1'b0 : 1'b1;
                #1;
                chk({v.name, " mreq"}, {31'd0, mreq}, 32'd1);
                chk({v.name, " stall"}, {31'd0, core_stall}, 32'd1);
                chk({v.name, " write"}, {31'd0, write_o}, {31'd0, v.wr});
                chk({v.name, " size"}, {30'd0, size_o}, {30'd0, v.size});
                chk({v.name, " dad"}, dad, v.exp_dad);
                if (v.wr) chk({v.name, " ddt"}, ddt, v.exp_ddt);
                tick();
            end
            ackd_n = 1'b1;
            tb_en  = 1'b1;
            tb_ddt = PROBE;
            #1;
            chk({v.name, " done mreq"}, {31'd0, mreq}, 32'd0);
            chk({v.name, " done stall"}, {31'd0, core_stall}, 32'd0);
            chk({v.name, " done err"}, {31'd0, core_err}, 32'd0);
            chk({v.name, " done write"}, {31'd0, write_o}, 32'd0);
            chk({v.name, " done rdata"}, core_rdata, v.exp_rdata);
            chk({v.name, " done ddt released"}, ddt, PROBE);
            // core_req still high in DONE; it must not start another access
            core_req = 1'b0;
            tick();
            chk({v.name, " idle mreq"}, {31'd0, mreq}, 32'd0);
            chk({v.name, " idle rdata"}, core_rdata, v.exp_rdata);
        end
        tb_en = 1'b0;
    endtask

    initial begin
        int cnt;
        n_cmp = 0;
        n_bad = 0;

        //            name     wr  size  uns addr          wdata         mem           w  err exp_ddt       exp_dad       exp_rdata
        vecs[0]  = mk("lw100", 0, 2'b00, 0, 32'h100, 32'h0,         32'hDEADBEEF, 2, 0, 32'h0,         32'h100, 32'hDEADBEEF);
        vecs[1]  = mk("lb103", 0, 2'b10, 0, 32'h103, 32'h0,         32'h80123456, 0, 0, 32'h0,         32'h100, 32'hFFFFFF80);
        vecs[2]  = mk("lbu103",0, 2'b10, 1, 32'h103, 32'h0,         32'h80123456, 1, 0, 32'h0,         32'h100, 32'h00000080);
        vecs[3]  = mk("lh102", 0, 2'b01, 0, 32'h102, 32'h0,         32'h80123456, 0, 0, 32'h0,         32'h100, 32'hFFFF8012);
        vecs[4]  = mk("sb201", 1, 2'b10, 0, 32'h201, 32'h000000A5, 32'h0,         1, 0, 32'hA5A5A5A5, 32'h200, 32'hFFFF8012);
        vecs[5]  = mk("lw102", 0, 2'b00, 0, 32'h102, 32'h0,         32'h0,         0, 1, 32'h0,         32'h0,   32'hFFFF8012);
        vecs[6]  = mk("sh101", 1, 2'b01, 0, 32'h101, 32'h0000BEEF, 32'h0,         0, 1, 32'h0,         32'h0,   32'hFFFF8012);
        vecs[7]  = mk("lhu100",0, 2'b01, 1, 32'h100, 32'h0,         32'h1234F00D, 1, 0, 32'h0,         32'h100, 32'h0000F00D);
        vecs[8]  = mk("lb101", 0, 2'b10, 0, 32'h101, 32'h0,         32'h00007F00, 0, 0, 32'h0,         32'h100, 32'h0000007F);
        vecs[9]  = mk("sh202", 1, 2'b01, 0, 32'h202, 32'hFFFFBEEF, 32'h0,         2, 0, 32'hBEEFBEEF, 32'h200, 32'h0000007F);
        vecs[10] = mk("sw204", 1, 2'b00, 0, 32'h204, 32'h12345678, 32'h0,         0, 0, 32'h12345678, 32'h204, 32'h0000007F);
        vecs[11] = mk("lw104ack4", 0, 2'b00, 0, 32'h104, 32'h0,     32'hCAFEF00D, 3, 0, 32'h0,         32'h104, 32'hCAFEF00D);
        vecs[12] = mk("l11_108",0, 2'b11, 0, 32'h108, 32'h0,        32'h89ABCDEF, 0, 0, 32'h0,         32'h108, 32'h89ABCDEF);
        vecs[13] = mk("lb102", 0, 2'b10, 0, 32'h102, 32'h0,         32'h00C30000, 0, 0, 32'h0,         32'h100, 32'hFFFFFFC3);
        vecs[14] = mk("lh100", 0, 2'b01, 0, 32'h100, 32'h0,         32'h00017FFF, 1, 0, 32'h0,         32'h100, 32'h00007FFF);

        rst        = 1'b0;
        core_req   = 1'b0;
        core_write = 1'b0;
        core_size  = 2'b00;
        core_uns   = 1'b0;
        core_addr  = '0;
        core_wdata = '0;
        ackd_n     = 1'b1;
        tb_en      = 1'b1;
        tb_ddt     = PROBE;
        #2;
        chk("rst mreq", {31'd0, mreq}, 32'd0);
        chk("rst write", {31'd0, write_o}, 32'd0);
        chk("rst size", {30'd0, size_o}, 32'd0);
        chk("rst dad", dad, 32'd0);
        chk("rst rdata", core_rdata, 32'd0);
        chk("rst err", {31'd0, core_err}, 32'd0);
        chk("rst stall", {31'd0, core_stall}, 32'd0);
        chk("rst ddt released", ddt, PROBE);
        #10;
        rst = 1'b1;
        tick();

        for (int k = 0; k < 15; k++) run_vec(vecs[k]);

        // Ack never arrives: TIMEOUT=4 gives exactly 4 MREQ cycles then an error pulse
        tb_en      = 1'b0;
        core_req   = 1'b1;
        core_write = 1'b0;
        core_size  = 2'b00;
        core_addr  = 32'h300;
        ackd_n     = 1'b1;
        tick();
        core_req = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20 && mreq; k++) begin
            cnt++;
            tick();
        end
        chk("timeout mreq cycles", cnt, 32'd4);
        chk("timeout err", {31'd0, core_err}, 32'd1);
        chk("timeout stall", {31'd0, core_stall}, 32'd0);
        chk("timeout rdata kept", core_rdata, 32'h00007FFF);
        tick();
        chk("timeout err pulse end", {31'd0, core_err}, 32'd0);

        // Reset mid-store: bus released without a clock edge
        core_req   = 1'b1;
        core_write = 1'b1;
        core_size  = 2'b00;
        core_addr  = 32'h120;
        core_wdata = 32'hCAFE0001;
        tick();
        #2;
        chk("pre-rst mreq", {31'd0, mreq}, 32'd1);
        chk("pre-rst ddt", ddt, 32'hCAFE0001);
        rst      = 1'b0;
        core_req = 1'b0;
        tb_en    = 1'b1;
        tb_ddt   = PROBE;
        #1;
        chk("midrst mreq", {31'd0, mreq}, 32'd0);
        chk("midrst write", {31'd0, write_o}, 32'd0);
        chk("midrst stall", {31'd0, core_stall}, 32'd0);
        chk("midrst ddt released", ddt, PROBE);
        chk("midrst dad", dad, 32'd0);
        chk("midrst rdata", core_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        run_vec(mk("b2b_lw", 0, 2'b00, 0, 32'h400, 32'h0, 32'h01020304, 0, 0, 32'h0,
                   32'h400, 32'h01020304));
        run_vec(mk("b2b_lhu", 0, 2'b01, 1, 32'h402, 32'h0, 32'h9876ABCD, 1, 0, 32'h0,
                   32'h400, 32'h00009876));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
